// File: rtl/ieee754_divider_seq.sv
// Purpose: sequential binary32 divider a/b, radix-2 restoring mantissa loop, truncating, denormals flushed.
// Latency: done pulses 28 cycles after acceptance on the normal path, 3 cycles (2 edges after accept) for zero operands.
// Backpressure: none; start is taken only while idle, and starts arriving while busy are dropped, not queued.
module ieee754_divider_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UNPACK = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_PACK   = 2'd3;

    // Operand class decided in UNPACK, consumed in PACK.
    localparam logic [1:0] K_NORMAL = 2'd0;
    localparam logic [1:0] K_DIV0   = 2'd1;
    localparam logic [1:0] K_ZERO   = 2'd2;

    // 25 quotient bits: iterations 0..24.
    localparam logic [4:0] LAST_ITER = 5'd24;

    logic [1:0]        state;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic              sign_reg;
    logic [1:0]        kind_reg;
    logic signed [9:0] exp_diff;
    logic [23:0]       mb_reg;
    logic [24:0]       rem_reg;
    logic [24:0]       quo_reg;
    logic [4:0]        iter_cnt;

    logic [7:0]        a_exp;
    logic [7:0]        b_exp;

    logic              trial_ok;
    logic [24:0]       trial_diff;
    logic [24:0]       rem_sel;
    logic [24:0]       rem_next;

    logic signed [9:0] pack_exp;
    logic [22:0]       pack_frac;
    logic [31:0]       pack_result;
    logic              pack_dbz;

    assign a_exp = a_reg[30:23];
    assign b_exp = b_reg[30:23];

    // One restoring step: subtract divisor if it fits, then shift the remainder up.
    always_comb begin
        trial_ok   = (rem_reg >= {1'b0, mb_reg});
        trial_diff = rem_reg - {1'b0, mb_reg};
        rem_sel    = trial_ok ? trial_diff : rem_reg;
        rem_next   = rem_sel << 1;
    end

    // Normalise the quotient, apply the exponent bias and clamp to the representable range.
    always_comb begin
        pack_exp    = exp_diff + (quo_reg[24] ? 10'sd127 : 10'sd126);
        pack_frac   = quo_reg[24] ? quo_reg[23:1] : quo_reg[22:0];
        pack_result = 32'h0000_0000;
        pack_dbz    = 1'b0;
        case (kind_reg)
            K_DIV0: begin
                pack_result = {sign_reg, 8'hFF, 23'd0};
                pack_dbz    = 1'b1;
            end
            K_ZERO: begin
                pack_result = 32'h0000_0000;
            end
            default: begin
                if (pack_exp >= 10'sd255) begin
                    pack_result = {sign_reg, 8'hFF, 23'd0};
                end else if (pack_exp <= 10'sd0) begin
                    pack_result = 32'h0000_0000;
                end else begin
                    pack_result = {sign_reg, pack_exp[7:0], pack_frac};
                end
            end
        endcase
    end

    // Control FSM plus datapath registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'h0000_0000;
            div_by_zero <= 1'b0;
            a_reg       <= 32'h0000_0000;
            b_reg       <= 32'h0000_0000;
            sign_reg    <= 1'b0;
            kind_reg    <= K_NORMAL;
            exp_diff    <= 10'sd0;
            mb_reg      <= 24'd0;
            rem_reg     <= 25'd0;
            quo_reg     <= 25'd0;
            iter_cnt    <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        busy  <= 1'b1;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_reg <= a_reg[31] ^ b_reg[31];
                    exp_diff <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
                    rem_reg  <= {2'b01, a_reg[22:0]};
                    mb_reg   <= {1'b1, b_reg[22:0]};
                    quo_reg  <= 25'd0;
                    iter_cnt <= 5'd0;
                    // A zero exponent means zero regardless of fraction; divisor zero wins.
                    if (b_exp == 8'd0) begin
                        kind_reg <= K_DIV0;
                        state    <= S_PACK;
                    end else if (a_exp == 8'd0) begin
                        kind_reg <= K_ZERO;
                        state    <= S_PACK;
                    end else begin
                        kind_reg <= K_NORMAL;
                        state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_reg  <= rem_next;
                    quo_reg  <= {quo_reg[23:0], trial_ok};
                    iter_cnt <= iter_cnt + 5'd1;
                    if (iter_cnt == LAST_ITER) begin
                        state <= S_PACK;
                    end
                end
                S_PACK: begin
                    result      <= pack_result;
                    div_by_zero <= pack_dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ieee754_divider_seq.sv
// Purpose: self-checking bench for ieee754_divider_seq against an arithmetic reference model.
// Latency: model predicts busy/done/result on every cycle from acceptance time and operand class.
// Backpressure: model drops starts while an operation is outstanding, as the DUT must.
module tb_ieee754_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    ieee754_divider_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Reference: q = floor(ma*2^24/mb) by integer division, then normalise and clamp.
    function automatic logic [32:0] model_div(input logic [31:0] x, input logic [31:0] y);
        logic        sign;
        int          ex, ey, e;
        longint      ma, mb, q;
        logic [22:0] frac;
        sign = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if (ey == 0) return {1'b1, sign, 8'hFF, 23'd0};
        if (ex == 0) return 33'd0;
        ma = longint'({1'b1, x[22:0]});
        mb = longint'({1'b1, y[22:0]});
        q  = (ma * 64'd16777216) / mb;
        if (q >= 64'd16777216) begin
            e    = ex - ey + 127;
            frac = 23'((q / 2) % 64'd8388608);
        end else begin
            e    = ex - ey + 126;
            frac = 23'(q % 64'd8388608);
        end
        if (e >= 255) return {1'b0, sign, 8'hFF, 23'd0};
        if (e <= 0) return 33'd0;
        return {1'b0, sign, 8'(e), frac};
    endfunction

    function automatic bit model_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'd0) || (y[30:23] == 8'd0);
    endfunction

    // Model state: expected outputs for the cycle following each rising edge.
    bit          m_known  = 1'b0;
    bit          m_active = 1'b0;
    int          m_due    = 0;
    logic [32:0] m_pend;
    logic        exp_busy, exp_done, exp_dbz;
    logic [31:0] exp_result;

    always @(posedge clk) begin
        cyc++;
        exp_done = 1'b0;
        if (!rst_n) begin
            m_known    = 1'b1;
            m_active   = 1'b0;
            exp_busy   = 1'b0;
            exp_result = 32'd0;
            exp_dbz    = 1'b0;
        end else if (m_active && cyc == m_due) begin
            m_active   = 1'b0;
            exp_busy   = 1'b0;
            exp_done   = 1'b1;
            exp_result = m_pend[31:0];
            exp_dbz    = m_pend[32];
        end else if (!m_active && start) begin
            m_active = 1'b1;
            m_pend   = model_div(a, b);
            m_due    = cyc + (model_special(a, b) ? 2 : 27);
            exp_busy = 1'b1;
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_known) begin
            check("cmp_busy", {31'd0, busy}, {31'd0, exp_busy});
            check("cmp_done", {31'd0, done}, {31'd0, exp_done});
            check("cmp_result", result, exp_result);
            check("cmp_dbz", {31'd0, div_by_zero}, {31'd0, exp_dbz});
        end
    end

    task automatic launch(input logic [31:0] x, input logic [31:0] y, output int e0);
        start = 1'b1;
        a     = x;
        b     = y;
        e0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int e0, output int lat);
        for (int n = 0; n < 60 && !done; n++) @(negedge clk);
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        lat = cyc - e0;
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int e0, e1, lat, seen;
        vecs[0] = '{32'h41218000, 32'h40080000, 32'h40980000, 1'b0, 27};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27};
        vecs[2] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 27};
        vecs[3] = '{32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 2};
        vecs[4] = '{32'hC0A00000, 32'h00000000, 32'hFF800000, 1'b1, 2};
        vecs[5] = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 2};
        vecs[6] = '{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 2};
        vecs[7] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 27};
        vecs[8] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 27};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; literals pin both the DUT and the reference model.
        foreach (vecs[i]) begin
            check($sformatf("model%0d", i), model_div(vecs[i].x, vecs[i].y)[31:0], vecs[i].res);
            launch(vecs[i].x, vecs[i].y, e0);
            wait_done($sformatf("vec%0d", i), e0, lat);
            check($sformatf("vec%0d_res", i), result, vecs[i].res);
            check($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            @(negedge clk);
        end

        // Start pulse with new operands mid-DIV is ignored.
        launch(32'h3F800000, 32'h40400000, e0);
        repeat (10) @(negedge clk);
        launch(32'h40A00000, 32'h00000000, e1);
        a = 32'h12345678;
        b = 32'h87654321;
        wait_done("ignore", e0, lat);
        check("ignore_res", result, 32'h3EAAAAAA);
        check("ignore_dbz", {31'd0, div_by_zero}, 32'd0);
        check("ignore_lat", lat, 27);
        @(negedge clk);

        // Start asserted in the done cycle is accepted.
        launch(32'h3F800000, 32'h40400000, e0);
        wait_done("b2b_first", e0, lat);
        check("b2b_first_res", result, 32'h3EAAAAAA);
        launch(32'hC0C00000, 32'h40000000, e1);
        wait_done("b2b_second", e1, lat);
        check("b2b_second_res", result, 32'hC0400000);
        check("b2b_second_lat", lat, 27);
        @(negedge clk);

        // Reset at DIV iteration 10 (edge E11) aborts with no done.
        launch(32'h41218000, 32'h40080000, e0);
        while (cyc < e0 + 10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
